// File: rtl/sw_decoder_scan.sv
// sw_decoder_scan: registered SEL_W-to-2**SEL_W one-hot decoder for the LED bank.
// Raw switches are synchronised and debounced. An auto-scan mode walks the lit LED.
//
// Ports
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   SW     raw select switches, asynchronous to clk
//   MODE   raw mode switch: 0 = decode, 1 = scan (synchronised, not debounced)
//   EN     synchronous enable; 0 blanks LED on the next edge
//   LED    registered one-hot output, active-high
//   STEP   registered one-cycle pulse whenever LED takes a new value
//
// Build option
//   SCAN_PINGPONG_EN  when defined, the scan bounces between the end positions.
//                     When undefined, the scan wraps from the top position to 0.
module sw_decoder_scan #(
   parameter int unsigned SEL_W      = 3,
   parameter int unsigned DEB_CYCLES = 1000,
   parameter int unsigned SCAN_DIV   = 50000000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [SEL_W-1:0]         SW,
   input  logic                     MODE,
   input  logic                     EN,
   output logic [(1 << SEL_W)-1:0]  LED,
   output logic                     STEP
);

   localparam int unsigned LED_W = 1 << SEL_W;
   localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
`ifdef SCAN_PINGPONG_EN
   localparam logic [SEL_W-1:0] POS_MAX  = SEL_W'(LED_W - 1);
`endif

   localparam logic [0:0] ST_DECODE = 1'b0;
   localparam logic [0:0] ST_SCAN   = 1'b1;

   function automatic logic [LED_W-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [LED_W-1:0] r;
      r      = '0;
      r[idx] = 1'b1;
      return r;
   endfunction

   // Two-flop synchronisers for the asynchronous switch inputs
   logic [SEL_W-1:0] sw_s1, sw_s2;
   logic             mode_s1, mode_s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_s1   <= '0;
         sw_s2   <= '0;
         mode_s1 <= 1'b0;
         mode_s2 <= 1'b0;
      end else begin
         sw_s1   <= SW;
         sw_s2   <= sw_s1;
         mode_s1 <= MODE;
         mode_s2 <= mode_s1;
      end
   end

   // Debounce: accept the candidate once it has been seen for DEB_CYCLES synced samples
   logic [SEL_W-1:0] cand, sel_q;
   logic [DEB_W-1:0] deb_cnt, deb_inc;

   assign deb_inc = deb_cnt + DEB_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand    <= '0;
         sel_q   <= '0;
         deb_cnt <= '0;
      end else if (sw_s2 != cand) begin
         cand    <= sw_s2;
         deb_cnt <= '0;
         // With a single-sample debounce the reload sample is already the accepting one
         if (DEB_LAST == '0) sel_q <= sw_s2;
      end else if (deb_cnt != DEB_LAST) begin
         deb_cnt <= deb_inc;
         if (deb_inc == DEB_LAST) sel_q <= cand;
      end
   end

   // FSM and scan datapath
   logic [0:0]       state, state_d;
   logic [SEL_W-1:0] pos, pos_d, pos_step;
   logic [PRE_W-1:0] presc, presc_d;
   logic [LED_W-1:0] led_d;
`ifdef SCAN_PINGPONG_EN
   logic             dir_up, dir_up_d, dir_step;
`endif

   // Next scan position after a terminal count
`ifdef SCAN_PINGPONG_EN
   always_comb begin
      pos_step = pos;
      dir_step = dir_up;
      if (dir_up) begin
         if (pos == POS_MAX) begin
            pos_step = pos - SEL_W'(1);
            dir_step = 1'b0;
         end else begin
            pos_step = pos + SEL_W'(1);
         end
      end else begin
         if (pos == '0) begin
            pos_step = pos + SEL_W'(1);
            dir_step = 1'b1;
         end else begin
            pos_step = pos - SEL_W'(1);
         end
      end
   end
`else
   assign pos_step = pos + SEL_W'(1);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_DECODE;
         pos    <= '0;
         presc  <= '0;
         LED    <= '0;
         STEP   <= 1'b0;
`ifdef SCAN_PINGPONG_EN
         dir_up <= 1'b1;
`endif
      end else begin
         state  <= state_d;
         pos    <= pos_d;
         presc  <= presc_d;
         LED    <= led_d;
         STEP   <= (led_d != LED);
`ifdef SCAN_PINGPONG_EN
         dir_up <= dir_up_d;
`endif
      end
   end

   always_comb begin
      state_d  = state;
      pos_d    = pos;
      presc_d  = presc;
      led_d    = LED;
`ifdef SCAN_PINGPONG_EN
      dir_up_d = dir_up;
`endif
      case (state)
         ST_DECODE: begin
            led_d = onehot(sel_q);
            if (mode_s2) begin
               state_d  = ST_SCAN;
               pos_d    = sel_q;
               presc_d  = '0;
`ifdef SCAN_PINGPONG_EN
               dir_up_d = 1'b1;
`endif
            end
         end
         ST_SCAN: begin
            if (!mode_s2) begin
               // Leaving scan wins over a coincident terminal count
               state_d = ST_DECODE;
               led_d   = onehot(sel_q);
            end else begin
               led_d = onehot(pos);
               if (EN) begin
                  if (presc == PRE_LAST) begin
                     presc_d  = '0;
                     pos_d    = pos_step;
                     led_d    = onehot(pos_step);
`ifdef SCAN_PINGPONG_EN
                     dir_up_d = dir_step;
`endif
                  end else begin
                     presc_d = presc + PRE_W'(1);
                  end
               end
            end
         end
         default: state_d = ST_DECODE;
      endcase
      // Blanking overrides the target; prescaler and position hold while disabled
      if (!EN) led_d = '0;
   end

endmodule

// File: tb/tb_sw_decoder_scan.sv
// Bench for sw_decoder_scan (SEL_W=3, DEB_CYCLES=4, SCAN_DIV=3).
// Stimulus pushes {LED value, cycle} expectations. A monitor pops one expectation on every STEP pulse.
module tb_sw_decoder_scan;

   localparam int unsigned SEL_W = 3;
   localparam int unsigned DEB   = 4;
   localparam int unsigned DIV   = 3;

   logic       clk;
   logic       rst_n;
   logic [2:0] sw;
   logic       mode;
   logic       en;
   logic [7:0] led;
   logic       step;

   sw_decoder_scan #(
      .SEL_W      (SEL_W),
      .DEB_CYCLES (DEB),
      .SCAN_DIV   (DIV)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .SW    (sw),
      .MODE  (mode),
      .EN    (en),
      .LED   (led),
      .STEP  (step)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Index of the most recent rising edge
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] led;
      int         cyc;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;

   logic [7:0] seq [6];

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_at(input logic [7:0] v, input int c);
      q.push_back('{led: v, cyc: c});
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   function automatic logic [7:0] oh(input int i);
      logic [7:0] r;
      r = '0;
      r[i[2:0]] = 1'b1;
      return r;
   endfunction

   // Monitor: every STEP pulse must match the next expected LED value and edge
   always @(posedge clk) begin
      #1;
      if (step === 1'b1) begin
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL step_unexpected: edge %0d led=%h, no change required", cyc, led);
         end else begin
            mon_e = q.pop_front();
            if (led !== mon_e.led || cyc != mon_e.cyc) begin
               failures++;
               $display("FAIL step_value: edge %0d led=%h, required edge %0d led=%h",
                        cyc, led, mon_e.cyc, mon_e.led);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish at edge %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cur;
      int cm;

`ifdef SCAN_PINGPONG_EN
      seq[0] = 8'h80; seq[1] = 8'h40; seq[2] = 8'h20;
      seq[3] = 8'h10; seq[4] = 8'h08; seq[5] = 8'h04;
`else
      seq[0] = 8'h80; seq[1] = 8'h01; seq[2] = 8'h02;
      seq[3] = 8'h04; seq[4] = 8'h08; seq[5] = 8'h10;
`endif

      // Reset with SW=5 held; LED goes to 01 on the first edge, then 20 after sync+debounce
      rst_n = 1'b0;
      sw    = 3'd5;
      mode  = 1'b0;
      en    = 1'b1;
      tick(3);
      chk("reset_led", led, 8'h00);
      chk("reset_step", {7'b0, step}, 8'h00);
      expect_at(8'h01, cyc + 1);
      expect_at(8'h20, cyc + 7);
      rst_n = 1'b1;
      tick(15);
      cur = 5;

      // Decode sweep: each new SW value shows on LED 7 edges later
      for (int i = 0; i < 8; i++) begin
         sw = 3'(i);
         if (i != cur) expect_at(oh(i), cyc + 7);
         cur = i;
         tick(20);
      end

      // Bounce 5<->0 every 2 cycles, ending on 5: only the final settle is accepted
      for (int k = 0; k < 15; k++) begin
         sw = (k % 2 == 0) ? 3'd5 : 3'd0;
         if (k == 14) expect_at(8'h20, cyc + 7);
         tick(2);
      end
      tick(18);

      // Scan from 6
      sw = 3'd6;
      expect_at(8'h40, cyc + 7);
      tick(20);
      cm   = cyc;
      mode = 1'b1;
      for (int k = 0; k < 4; k++) expect_at(seq[k], cm + 6 + 3 * k);
      tick(16);

      // Blank for 10 cycles; prescaler was at 1 and resumes from there
      en = 1'b0;
      expect_at(8'h00, cyc + 1);
      tick(10);
      en = 1'b1;
      expect_at(seq[3], cyc + 1);
      expect_at(seq[4], cyc + 2);
      expect_at(seq[5], cyc + 5);
      tick(6);

      // Asynchronous reset between edges clears LED immediately
      #2;
      rst_n = 1'b0;
      mode  = 1'b0;
      sw    = 3'd2;
      #1;
      chk("async_reset_led", led, 8'h00);
      chk("async_reset_step", {7'b0, step}, 8'h00);
      tick(3);
      expect_at(8'h01, cyc + 1);
      expect_at(8'h04, cyc + 7);
      rst_n = 1'b1;
      tick(20);
      chk("final_led", led, 8'h04);

      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL pending_expectations: %0d left, required 0", q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
